// File: rtl/cas_tx_sequencer.sv
// Cassette write sequencer for the Electron tape interface.
// Buffers bytes in a 2-entry FIFO, frames each as start(0) + 8 data bits
// LSB-first + stop(1), and generates the tape square wave from a 24-bit
// phase accumulator. A leader tone precedes the first frame; high-tone
// carrier fills any gap between frames.
//
// Handshake: a byte is taken on any clk edge where tx_valid && tx_ready.
// tx_ready is registered and always equals (fifo_count < 2), so the
// producer may hold tx_valid with stable tx_data until it sees ready.
// Pushes are taken in every state, IDLE included.
module cas_tx_sequencer #(
  parameter logic [23:0] STP = 24'd3333
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] leader_len,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        dout,
  output logic        busy,
  output logic        byte_done,
  output logic        underrun,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEADER  = 3'd1,
    S_CARRIER = 3'd2,
    S_START   = 3'd3,
    S_DATA    = 3'd4,
    S_STOP    = 3'd5
  } state_t;

  state_t      state;
  logic [23:0] acc;
  logic [1:0]  tick_cnt;
  logic [15:0] leader_cnt;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_cnt;
  logic        enable_q;

  logic [7:0]  fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_count;
  logic [1:0]  count_nxt;

  logic [24:0] acc_sum;
  logic        tick;
  logic        cell_end;
  logic [1:0]  tick_nxt;
  logic        cur_bit;
  logic        push;
  logic        pop;
  logic        fifo_nonempty;

  assign dbg_state     = state;
  assign acc_sum       = {1'b0, acc} + {1'b0, STP};
  assign tick          = acc_sum[24];
  assign cell_end      = tick && (tick_cnt == 2'd3);
  assign tick_nxt      = tick_cnt + 2'd1;
  assign push          = tx_valid && tx_ready;
  assign fifo_nonempty = (fifo_count != 2'd0);
  assign count_nxt     = fifo_count + {1'b0, push} - {1'b0, pop};

  // Bit being sent in the current cell: start bit low, data from the shifter, all else high tone.
  always_comb begin
    cur_bit = 1'b1;
    case (state)
      S_START: cur_bit = 1'b0;
      S_DATA:  cur_bit = shift_reg[0];
      default: cur_bit = 1'b1;
    endcase
  end

  // A FIFO pop happens exactly on the edge that enters START.
  always_comb begin
    pop = 1'b0;
    if (fifo_nonempty) begin
      case (state)
        S_IDLE:            pop = enable && (leader_len == 16'd0);
        S_LEADER:          pop = cell_end && (leader_cnt == 16'd1);
        S_CARRIER, S_STOP: pop = cell_end && enable;
        default:           pop = 1'b0;
      endcase
    end
  end

  // Two-entry byte FIFO with registered ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      tx_ready   <= 1'b1;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= tx_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= count_nxt;
      tx_ready   <= (count_nxt < 2'd2);
    end
  end

  // Sequencer: tone timing, cell decisions at cell ends, registered outputs.
  // dout is computed from the post-edge tick count so it lines up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      acc        <= 24'd0;
      tick_cnt   <= 2'd0;
      leader_cnt <= 16'd0;
      shift_reg  <= 8'd0;
      bit_cnt    <= 3'd0;
      enable_q   <= 1'b0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      enable_q  <= enable;
      byte_done <= 1'b0;
      if (enable_q && !enable) begin
        underrun <= 1'b0;
      end
      if (state == S_IDLE) begin
        dout <= 1'b0;
        if (enable) begin
          acc        <= 24'd0;
          tick_cnt   <= 2'd0;
          leader_cnt <= leader_len;
          busy       <= 1'b1;
          dout       <= 1'b1;
          if (leader_len != 16'd0) begin
            state <= S_LEADER;
          end else if (pop) begin
            state     <= S_START;
            shift_reg <= fifo_mem[rd_ptr];
          end else begin
            state <= S_CARRIER;
          end
        end
      end else begin
        acc <= acc_sum[23:0];
        if (tick) begin
          tick_cnt <= tick_nxt;
          if (!cell_end) begin
            dout <= cur_bit ? ~tick_nxt[0] : ~tick_nxt[1];
          end else begin
            // Every cell begins high so the tone phase stays continuous.
            dout <= 1'b1;
            case (state)
              S_LEADER: begin
                if (leader_cnt == 16'd1) begin
                  if (pop) begin
                    state     <= S_START;
                    shift_reg <= fifo_mem[rd_ptr];
                  end else begin
                    state <= S_CARRIER;
                  end
                end else begin
                  leader_cnt <= leader_cnt - 16'd1;
                end
              end
              S_CARRIER: begin
                if (!enable) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  dout  <= 1'b0;
                end else if (pop) begin
                  state     <= S_START;
                  shift_reg <= fifo_mem[rd_ptr];
                end
              end
              S_START: begin
                state   <= S_DATA;
                bit_cnt <= 3'd0;
              end
              S_DATA: begin
                shift_reg <= {1'b0, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  state <= S_STOP;
                end
              end
              S_STOP: begin
                byte_done <= 1'b1;
                if (!enable) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  dout  <= 1'b0;
                end else if (pop) begin
                  state     <= S_START;
                  shift_reg <= fifo_mem[rd_ptr];
                end else begin
                  underrun <= 1'b1;
                  state    <= S_CARRIER;
                end
              end
              default: begin
                state <= S_IDLE;
                busy  <= 1'b0;
                dout  <= 1'b0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cas_tx_sequencer.sv
// Bench for cas_tx_sequencer. A fast-tone instance (tick every 4 clk) is
// driven by directed scenarios and random traffic and compared every clk
// against a cell/bit-queue reference model; a default-STP instance runs in
// parallel to measure real tick and cell timing.
module tb_cas_tx_sequencer;

  localparam logic [23:0] STP_T   = 24'd4194304;
  localparam longint      STP_DEF = 3333;

  // ---------------- clock / reset ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        reset, enable, tx_valid;
  logic [15:0] leader_len;
  logic [7:0]  tx_data;
  logic        tx_ready, dout, busy, byte_done, underrun;
  logic [2:0]  dbg_state;

  logic        d_reset, d_enable;
  logic        d_tx_ready, d_dout, d_busy, d_byte_done, d_underrun;
  logic [2:0]  d_dbg_state;
  bit          def_done;

  cas_tx_sequencer #(.STP(STP_T)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .leader_len(leader_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dout(dout), .busy(busy), .byte_done(byte_done), .underrun(underrun),
    .dbg_state(dbg_state)
  );

  cas_tx_sequencer u_dut_def (
    .clk(clk), .reset(d_reset), .enable(d_enable), .leader_len(16'd3),
    .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(d_tx_ready),
    .dout(d_dout), .busy(d_busy), .byte_done(d_byte_done), .underrun(d_underrun),
    .dbg_state(d_dbg_state)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds queued bytes; m_bits holds the remaining cells of the frame
  // in flight (front = cell now on tape). Leader cells are counted down;
  // with neither leader nor frame bits pending the tape carries high tone.
  logic [7:0] exp_q[$];
  bit         m_bits[$];
  int         m_leader, m_ticks;
  longint     m_n;
  bit         m_active, m_underrun, m_bdone, m_prev_en;

  function automatic bit tick_at(input longint n);
    return ((n * longint'(STP_T)) >> 24) != (((n - 1) * longint'(STP_T)) >> 24);
  endfunction

  function automatic void start_frame();
    logic [7:0] d;
    d = exp_q.pop_front();
    m_bits.delete();
    m_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) m_bits.push_back(d[i]);
    m_bits.push_back(1'b1);
  endfunction

  function automatic void cell_finished();
    if (m_leader > 0) begin
      m_leader--;
      if (m_leader == 0 && exp_q.size() > 0) start_frame();
    end else if (m_bits.size() > 0) begin
      void'(m_bits.pop_front());
      if (m_bits.size() == 0) begin
        m_bdone = 1'b1;
        if (!enable) m_active = 1'b0;
        else if (exp_q.size() > 0) start_frame();
        else m_underrun = 1'b1;
      end
    end else begin
      if (!enable) m_active = 1'b0;
      else if (exp_q.size() > 0) start_frame();
    end
  endfunction

  function automatic void model_step();
    bit do_push;
    do_push = tx_valid && (exp_q.size() < 2);
    if (reset) begin
      exp_q.delete();
      m_bits.delete();
      m_leader = 0; m_ticks = 0; m_n = 0;
      m_active = 1'b0; m_underrun = 1'b0; m_bdone = 1'b0; m_prev_en = 1'b0;
      return;
    end
    m_bdone = 1'b0;
    if (m_prev_en && !enable) m_underrun = 1'b0;
    if (!m_active) begin
      if (enable) begin
        m_active = 1'b1;
        m_n = 0;
        m_ticks = 0;
        m_bits.delete();
        m_leader = int'(leader_len);
        if (m_leader == 0 && exp_q.size() > 0) start_frame();
      end
    end else begin
      m_n++;
      if (tick_at(m_n)) begin
        if (m_ticks == 3) begin
          m_ticks = 0;
          cell_finished();
        end else begin
          m_ticks++;
        end
      end
    end
    if (do_push) exp_q.push_back(tx_data);
    m_prev_en = enable;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    bit         cur, e_dout;
    logic [1:0] t2;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    t2  = 2'(m_ticks);
    cur = (m_leader > 0) ? 1'b1 : ((m_bits.size() > 0) ? m_bits[0] : 1'b1);
    e_dout = m_active ? (cur ? ~t2[0] : ~t2[1]) : 1'b0;
    check_eq("dout", dout, e_dout);
    check_eq("busy", busy, m_active);
    check_eq("byte_done", byte_done, m_bdone);
    check_eq("underrun", underrun, m_underrun);
    check_eq("tx_ready", tx_ready, exp_q.size() < 2);
  endtask

  task automatic push_byte(input logic [7:0] d);
    bit acc;
    int k;
    acc = 1'b0;
    k = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!acc && k < 400) begin
      acc = (exp_q.size() < 2);
      cycle();
      k++;
    end
    tx_valid = 1'b0;
    check_eq("push_accept", acc, 1);
  endtask

  task automatic run_until_bdone(input int max, output int t);
    int k;
    k = 0;
    t = -100000;
    while (k < max) begin
      cycle();
      k++;
      if (byte_done === 1'b1) begin
        t = cyc;
        break;
      end
    end
    check_eq("bdone_seen", (t >= 0), 1);
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < max) begin
      cycle();
      k++;
    end
    check_eq("idle_reached", busy, 0);
  endtask

  // ---------------- default-STP timing ----------------
  initial begin
    int     n, k;
    longint t[0:8];
    longint exp_n;
    logic   prev;
    def_done = 1'b0;
    d_reset  = 1'b1;
    d_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    d_reset  = 1'b0;
    d_enable = 1'b1;
    @(posedge clk);
    #1;
    check_eq("def_busy", d_busy, 1);
    prev = d_dout;
    n = 0;
    k = 0;
    t[0] = 0;
    while (k < 8 && n < 45000) begin
      @(posedge clk);
      n++;
      #1;
      if (d_dout !== prev) begin
        k++;
        prev = d_dout;
        t[k] = n;
        exp_n = (longint'(k) * 64'd16777216 + STP_DEF - 1) / STP_DEF;
        check_eq("def_tick_time", n, exp_n);
        check_eq("def_tick_gap", (t[k] - t[k-1] >= 5033) && (t[k] - t[k-1] <= 5034), 1);
      end
    end
    check_eq("def_ticks_seen", k, 8);
    check_eq("def_cell0", (t[4] >= 20129) && (t[4] <= 20137), 1);
    check_eq("def_cell1", (t[8] - t[4] >= 20129) && (t[8] - t[4] <= 20137), 1);
    def_done = 1'b1;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int bcyc, t, t1, t2, t3, k;
    reset = 1'b1; enable = 1'b0; tx_valid = 1'b0; leader_len = 16'd0; tx_data = 8'h00;
    repeat (3) cycle();
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_dout", dout, 0);
    reset = 1'b0;
    cycle();

    // A5 after a 2-cell leader, pushed while idle
    leader_len = 16'd2;
    push_byte(8'hA5);
    enable = 1'b1;
    cycle();
    bcyc = cyc;
    check_eq("a5_busy_rise", busy, 1);
    check_eq("a5_dout_start", dout, 1);
    run_until_bdone(400, t);
    check_eq("a5_bdone_time", t - bcyc, 192);
    check_eq("a5_underrun", underrun, 1);
    repeat (20) cycle();
    enable = 1'b0;
    wait_idle(100);
    check_eq("a5_underrun_clr", underrun, 0);

    // three back-to-back bytes
    leader_len = 16'd1;
    push_byte(8'h00);
    push_byte(8'hFF);
    check_eq("b2b_ready_low", tx_ready, 0);
    enable = 1'b1;
    push_byte(8'h3C);
    run_until_bdone(400, t1);
    check_eq("b2b_underrun1", underrun, 0);
    run_until_bdone(400, t2);
    check_eq("b2b_underrun2", underrun, 0);
    run_until_bdone(400, t3);
    check_eq("b2b_gap1", t2 - t1, 160);
    check_eq("b2b_gap2", t3 - t2, 160);
    check_eq("b2b_underrun3", underrun, 1);
    enable = 1'b0;
    wait_idle(100);

    // zero leader, empty FIFO, late push
    leader_len = 16'd0;
    enable = 1'b1;
    cycle();
    bcyc = cyc;
    repeat (18) cycle();
    push_byte(8'h96);
    run_until_bdone(400, t);
    check_eq("nolead_bdone_time", t - bcyc, 192);

    // enable falls during data bit 3 of 55
    push_byte(8'h55);
    k = 0;
    while (m_bits.size() != 6 && k < 300) begin
      cycle();
      k++;
    end
    enable = 1'b0;
    cycle();
    check_eq("drop_underrun_clr", underrun, 0);
    check_eq("drop_still_busy", busy, 1);
    wait_idle(300);
    check_eq("drop_dout_idle", dout, 0);
    leader_len = 16'd1;
    enable = 1'b1;
    repeat (40) cycle();

    // reset mid-data with two bytes queued
    push_byte(8'hA1);
    push_byte(8'hB2);
    push_byte(8'hC3);
    k = 0;
    while (!(m_bits.size() >= 2 && m_bits.size() <= 8 && exp_q.size() == 2) && k < 300) begin
      cycle();
      k++;
    end
    check_eq("rst_mid_queued", tx_ready, 0);
    reset  = 1'b1;
    enable = 1'b0;
    cycle();
    check_eq("rst_mid_ready", tx_ready, 1);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_bdone", byte_done, 0);
    check_eq("rst_mid_dout", dout, 0);
    reset = 1'b0;
    repeat (5) cycle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        enable     = ~enable;
        leader_len = 16'($urandom_range(0, 2));
      end
      reset = ($urandom_range(0, 1999) == 0);
      cycle();
    end
    reset = 1'b0;
    tx_valid = 1'b0;

    k = 0;
    while (!def_done && k < 60000) begin
      @(posedge clk);
      k++;
    end
    check_eq("def_finished", def_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
